qspi_rx_fifo: RTL and testbench
===============================

Name: qspi_rx_fifo

Overview:
Receive-side buffer directly downstream of the QSPI receive shift register. It captures each completed receive word and masks it to the programmed transfer size. Words are queued in a DEPTH-entry synchronous FIFO and presented to the register/bus interface over a valid/ready handshake. It gives the QSPI controller a full indication for stalling, and raises watermark and overflow interrupts.

Parameters:
DEPTH, 8, number of 32-bit entries; power of two, minimum 2.
LW, $clog2(DEPTH)+1, width of the level and watermark fields; derived, not overridden.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  reset, asynchronous, active-low.
rx_valid_i  input  1  one-cycle pulse: the receive shifter has completed a word.
rx_data_i  input  32  assembled receive word from the shifter.
rx_size_i  input  6  transfer size in bits for this word.
rx_full_o  output  1  FIFO full; the controller must not start a new receive.
flush_i  input  1  synchronous clear of FIFO contents.
rd_valid_o  output  1  head entry available.
rd_ready_i  input  1  consumer accepts the head entry.
rd_data_o  output  32  head entry.
level_o  output  LW  number of occupied entries, 0..DEPTH.
watermark_i  input  LW  interrupt threshold.
wm_intr_o  output  1  level-sensitive watermark interrupt.
ovf_o  output  1  sticky overflow flag.
ovf_clr_i  input  1  clears ovf_o.
ovf_intr_o  output  1  one-cycle pulse on each dropped word.

Behaviour:
- Reset values:
  - Read and write pointers = 0, level_o = 0, rd_valid_o = 0, rx_full_o = 0.
  - ovf_o = 0, ovf_intr_o = 0, wm_intr_o = 0.
  - rd_data_o = 0; storage is not reset.
- Masking:
  - size_eff = min(rx_size_i, 32).
  - Stored word = rx_data_i AND ((1 << size_eff) - 1), computed in 33 bits, so size 32 gives all ones.
  - rx_size_i = 0: the pulse is ignored. No push and no overflow.
- Push:
  - push_req = rx_valid_i && size_eff != 0.
  - When not full: write at wptr, increment wptr modulo DEPTH.
- Pop:
  - pop = rd_valid_o && rd_ready_i; increment rptr modulo DEPTH.
  - rd_ready_i while empty has no effect.
- Occupancy flags:
  - rd_valid_o = level_o != 0.
  - rd_data_o = mem[rptr], first-word fall-through from storage.
  - Push-to-valid latency is 1 cycle. No same-cycle bypass when empty.
- Level update, all registered:
  - push only: +1. pop only: -1. Both: unchanged.
  - rx_full_o = level_o == DEPTH.
- Full with push_req:
  - If pop occurs in the same cycle, the push is accepted and the level stays DEPTH.
  - Otherwise the word is dropped, ovf_o is set, and ovf_intr_o pulses for 1 cycle on the next edge.
- Overflow flag:
  - ovf_clr_i clears ovf_o.
  - Overflow and ovf_clr_i in the same cycle: set wins.
- Flush:
  - flush_i zeroes the pointers and level next cycle.
  - A push or pop in the same cycle is discarded.
  - ovf_o is unaffected.
- Watermark:
  - wm_intr_o is registered: level_next >= watermark_i && watermark_i != 0.
  - watermark_i = 0 disables it.
  - watermark_i > DEPTH never fires.
- Reset mid-operation: all state returns to reset values immediately; any in-flight push is lost.

Decomposition:
- qspi_pkg holds:
  - QSPI_WORD_W = 32 and QSPI_SIZE_W = 6.
  - The size-clamp/mask function qspi_size_mask(size) returning a 32-bit mask, shared with the transmit path.
- One sub-module, qspi_rx_ram: DEPTH x 32 register array with a write port and an asynchronous read port.
- Pointer, level, flag and interrupt logic stay in qspi_rx_fifo.

Test Plan:
- Mask: push rx_data_i=32'hFFFF_FFFF, size 8, then size 32, then size 40 -> entries read back 32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF; size 0 pulse -> level unchanged.
- Fill/drain (DEPTH=8): push 8 words 1..8 with rd_ready_i=0 -> level_o=8, rx_full_o=1; drain -> data 1..8 in order, rd_valid_o falls after the 8th pop, level_o=0.
- Overflow: full FIFO, 9th push with rd_ready_i=0 -> dropped, ovf_o=1, one-cycle ovf_intr_o, level stays 8; ovf_clr_i -> ovf_o=0; simultaneous overflow and clear -> ovf_o=1.
- Full push+pop: level 8, push 32'hA5 with a pop in the same cycle -> level stays 8, no overflow, 32'hA5 read out 8th.
- Watermark: watermark_i=3, push 3 words -> wm_intr_o high the cycle after the 3rd push; pop 1 -> low; watermark_i=0 -> never high.
- Flush/reset: level 5, flush_i with a push in the same cycle -> level_o=0, rd_valid_o=0, ovf_o retained; assert rst_ni low mid-stream -> all outputs at reset values at once.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared QSPI constants and the transfer-size mask helper used by both the
// receive and transmit paths.
package qspi_pkg;
  localparam int QSPI_WORD_W = 32;
  localparam int QSPI_SIZE_W = 6;

  // Sizes above the word width clamp to a full word; the shift is done one bit
  // wider so that a size of 32 still yields all ones.
  function automatic logic [QSPI_WORD_W-1:0] qspi_size_mask(input logic [QSPI_SIZE_W-1:0] size);
    logic [QSPI_SIZE_W-1:0] eff;
    logic [QSPI_WORD_W:0]   m;
    eff = (size > QSPI_SIZE_W'(QSPI_WORD_W)) ? QSPI_SIZE_W'(QSPI_WORD_W) : size;
    m   = ({{QSPI_WORD_W{1'b0}}, 1'b1} << eff) - {{QSPI_WORD_W{1'b0}}, 1'b1};
    return m[QSPI_WORD_W-1:0];
  endfunction
endpackage

// File: rtl/qspi_rx_ram.sv
// DEPTH x 32 receive storage: one synchronous write port, one asynchronous read port.
module qspi_rx_ram
  import qspi_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [QSPI_WORD_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [QSPI_WORD_W-1:0] rdata
);
  logic [DEPTH-1:0][QSPI_WORD_W-1:0] mem;

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/qspi_rx_fifo.sv
// QSPI receive FIFO: masks completed words to the transfer size, queues them and
// presents them over valid/ready with full, watermark and overflow signalling.
module qspi_rx_fifo
  import qspi_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rx_valid_i,
  input  logic [QSPI_WORD_W-1:0] rx_data_i,
  input  logic [QSPI_SIZE_W-1:0] rx_size_i,
  output logic                   rx_full_o,
  input  logic                   flush_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [QSPI_WORD_W-1:0] rd_data_o,
  output logic [LW-1:0]          level_o,
  input  logic [LW-1:0]          watermark_i,
  output logic                   wm_intr_o,
  output logic                   ovf_o,
  input  logic                   ovf_clr_i,
  output logic                   ovf_intr_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]          wptr_q, rptr_q;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_intr_q, wm_q;
  logic                   push_req, full, pop, push, drop;
  logic [QSPI_WORD_W-1:0] ram_rdata;

  // A clamped size is zero only when the raw size is zero.
  assign push_req = rx_valid_i && (rx_size_i != '0);
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = rd_valid_o && rd_ready_i;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    level_d = level_q;
    if (flush_i)           level_d = '0;
    else if (push && !pop) level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      ovf_intr_q <= 1'b0;
      wm_q       <= 1'b0;
    end else begin
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + AW'(1);
        if (pop)  rptr_q <= rptr_q + AW'(1);
      end
      level_q    <= level_d;
      ovf_intr_q <= drop;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)           ovf_q <= 1'b1;
      else if (ovf_clr_i) ovf_q <= 1'b0;
      wm_q <= (level_d >= watermark_i) && (watermark_i != '0);
    end
  end

  qspi_rx_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i (clk_i),
    .we    (push && !flush_i),
    .waddr (wptr_q),
    .wdata (rx_data_i & qspi_size_mask(rx_size_i)),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

  assign level_o    = level_q;
  assign rd_valid_o = (level_q != '0);
  assign rx_full_o  = full;
  assign rd_data_o  = rd_valid_o ? ram_rdata : '0;
  assign ovf_o      = ovf_q;
  assign ovf_intr_o = ovf_intr_q;
  assign wm_intr_o  = wm_q;
endmodule

// File: tb/tb_qspi_rx_fifo.sv
// Directed bench for qspi_rx_fifo: queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the stimulus.
module tb_qspi_rx_fifo;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [31:0]   rx_data = '0;
  logic [5:0]    rx_size = '0;
  logic          rx_full;
  logic          flush = 1'b0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [31:0]   rd_data;
  logic [LW-1:0] level;
  logic [LW-1:0] watermark = '0;
  logic          wm_intr;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  logic          ovf_intr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qspi_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_size_i(rx_size), .rx_full_o(rx_full), .flush_i(flush), .rd_valid_o(rd_valid),
    .rd_ready_i(rd_ready), .rd_data_o(rd_data), .level_o(level), .watermark_i(watermark),
    .wm_intr_o(wm_intr), .ovf_o(ovf), .ovf_clr_i(ovf_clr), .ovf_intr_o(ovf_intr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the flag state.
  logic [31:0] mq[$];
  bit          m_ovf, m_ovf_intr, m_wm;

  function automatic logic [31:0] ref_mask(input logic [5:0] s);
    if (s >= 6'd32) return 32'hFFFF_FFFF;
    return (32'h1 << s) - 32'h1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_ovf_intr = 0; m_wm = 0;
    end else begin
      bit req, fl, pp, dr;
      req = rx_valid && (rx_size != 0);
      fl  = (mq.size() == DEPTH);
      pp  = (mq.size() != 0) && rd_ready;
      dr  = req && fl && !pp;
      if (flush) mq.delete();
      else begin
        if (pp) void'(mq.pop_front());
        if (req && !dr) mq.push_back(rx_data & ref_mask(rx_size));
      end
      m_ovf_intr = dr;
      if (dr) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_wm = (mq.size() >= int'(watermark)) && (watermark != 0);
    end
  end

  always @(negedge clk) begin
    chk("level", 32'(level), 32'(mq.size()));
    chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
    chk("rx_full", 32'(rx_full), 32'(mq.size() == DEPTH));
    if (mq.size() != 0) chk("rd_data", rd_data, mq[0]);
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("ovf_intr", 32'(ovf_intr), 32'(m_ovf_intr));
    chk("wm_intr", 32'(wm_intr), 32'(m_wm));
  end

  // Drive one cycle of inputs; returns at the following negedge.
  task automatic step(input bit v, input logic [31:0] d, input logic [5:0] s,
                      input bit rdy, input bit fl, input bit clr);
    rx_valid = v; rx_data = d; rx_size = s; rd_ready = rdy; flush = fl; ovf_clr = clr;
    @(negedge clk);
    rx_valid = 0; rd_ready = 0; flush = 0; ovf_clr = 0;
  endtask

  task automatic push(input logic [31:0] d, input logic [5:0] s);
    step(1, d, s, 0, 0, 0);
  endtask

  task automatic pop1();
    step(0, 0, 0, 1, 0, 0);
  endtask

  logic [31:0] exp_drain [8] = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'hA5};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", rd_data, 0);
    chk("rst_flags", {28'b0, rx_full, ovf, ovf_intr, wm_intr}, 0);
    rst_n = 1;
    @(negedge clk);

    // Masking
    push(32'hFFFF_FFFF, 6'd8);
    push(32'hFFFF_FFFF, 6'd32);
    push(32'hFFFF_FFFF, 6'd40);
    push(32'hFFFF_FFFF, 6'd0);
    chk("mask_level", 32'(level), 3);
    chk("mask_sz8", rd_data, 32'h0000_00FF);
    pop1();
    chk("mask_sz32", rd_data, 32'hFFFF_FFFF);
    pop1();
    chk("mask_sz40", rd_data, 32'hFFFF_FFFF);
    pop1();
    chk("mask_empty", 32'(rd_valid), 0);

    // Fill, overflow, clear
    for (int i = 1; i <= 8; i++) push(32'(i), 6'd32);
    chk("fill_level", 32'(level), 8);
    chk("fill_full", 32'(rx_full), 1);
    push(32'h9, 6'd32);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_pulse", 32'(ovf_intr), 1);
    chk("ovf_level", 32'(level), 8);
    step(0, 0, 0, 0, 0, 0);
    chk("ovf_pulse_end", 32'(ovf_intr), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("ovf_clr", 32'(ovf), 0);
    step(1, 32'hA, 6'd32, 0, 0, 1);
    chk("ovf_set_wins", 32'(ovf), 1);

    // Full push with simultaneous pop, then drain
    step(1, 32'hA5, 6'd32, 1, 0, 0);
    chk("pp_level", 32'(level), 8);
    chk("pp_no_ovf", 32'(ovf_intr), 0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", rd_data, exp_drain[i]);
      pop1();
    end
    chk("drain_valid", 32'(rd_valid), 0);
    chk("drain_level", 32'(level), 0);

    // Watermark
    watermark = LW'(3);
    push(32'h11, 6'd16);
    push(32'h22, 6'd16);
    chk("wm_below", 32'(wm_intr), 0);
    push(32'h33, 6'd16);
    chk("wm_hit", 32'(wm_intr), 1);
    pop1();
    chk("wm_drop", 32'(wm_intr), 0);
    watermark = '0;
    for (int i = 0; i < 3; i++) push(32'h40 + 32'(i), 6'd8);
    chk("wm_off", 32'(wm_intr), 0);

    // Flush at level 5 with a concurrent push
    chk("pre_flush_level", 32'(level), 5);
    step(1, 32'h77, 6'd8, 0, 1, 0);
    chk("flush_level", 32'(level), 0);
    chk("flush_valid", 32'(rd_valid), 0);
    chk("flush_ovf_kept", 32'(ovf), 1);

    // Watermark above DEPTH never fires
    watermark = LW'(9);
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i), 6'd12);
    chk("wm_gt_depth", 32'(wm_intr), 0);

    // Asynchronous reset mid-stream
    rx_valid = 1; rx_data = 32'hDEAD; rx_size = 6'd32;
    #2 rst_n = 0;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_data", rd_data, 0);
    chk("arst_flags", {28'b0, rx_full, ovf, ovf_intr, wm_intr}, 0);
    rx_valid = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
